// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment digit counter: segment patterns and digit range.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment patterns, active-high, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to 7-segment pattern decoder; out-of-range values show a dash.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   digit    in  4  value to display
//   pattern  out 7  segment pattern, active-high, bit0 = a .. bit6 = g
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (digit)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_digit_counter.sv
// Prescaled decimal up/down counter with pause and parallel load, driving a 7-segment display.
// Latency: digit and tick update on the terminal edge; segments and dp follow digit one clock later.
// Backpressure: none; ena=0 freezes every register, run=0 pauses prescaler and digit.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   ena                global enable; 0 holds all state and forces tick low
//   run                1 = prescaler advances, 0 = pause
//   up                 count direction, sampled only on step edges
//   load, load_val     synchronous load strobe and value (10..15 load as 0)
//   div_sel            speed-up, period = max(MAX_COUNT >> div_sel, 1)
//   segments, dp       registered display drive
//   digit              current count value 0..9
//   tick               one-cycle pulse per prescaler terminal event
module seg7_digit_counter
    import seg7_pkg::*;
#(
    parameter int MAX_COUNT = 10_000_000,
    parameter int PRE_W     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       run,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [2:0] div_sel,
    output logic [6:0] segments,
    output logic       dp,
    output logic [3:0] digit,
    output logic       tick
);

    localparam logic [PRE_W-1:0] MAX_P = PRE_W'(MAX_COUNT);

    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] shifted;
    logic [PRE_W-1:0] period_m1;
    logic             terminal;
    logic             stepped;     // a digit step happened on the previous enabled edge
    logic [6:0]       pattern;
    logic [3:0]       load_digit;
    logic [3:0]       step_digit;

    // Terminal compare uses >= so that shrinking the period via div_sel can
    // never leave the prescaler stranded above the new terminal value.
    always_comb begin
        shifted   = MAX_P >> div_sel;
        period_m1 = (shifted == '0) ? '0 : shifted - 1'b1;
        terminal  = run && (prescaler >= period_m1);
    end

    always_comb begin
        load_digit = (load_val > DIGIT_MAX) ? 4'd0 : load_val;
        if (up) begin
            step_digit = (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
        end else begin
            step_digit = (digit == 4'd0) ? DIGIT_MAX : digit - 4'd1;
        end
    end

    seg7_decoder u_decoder (
        .digit   (digit),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit     <= 4'd0;
            tick      <= 1'b0;
            dp        <= 1'b0;
            stepped   <= 1'b0;
            segments  <= SEG_0;
        end else if (!ena) begin
            tick <= 1'b0;
        end else begin
            tick     <= terminal;
            // Display path lags the digit register by one enabled clock.
            segments <= pattern;
            dp       <= dp ^ stepped;
            stepped  <= 1'b0;

            if (run) begin
                prescaler <= terminal ? '0 : prescaler + 1'b1;
            end

            // Load wins over a step on the same edge; tick is unaffected.
            if (load) begin
                digit     <= load_digit;
                prescaler <= '0;
            end else if (terminal) begin
                digit   <= step_digit;
                stepped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_digit_counter.sv
module tb_seg7_digit_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       run = 1'b1;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [2:0] div_sel = 3'd0;
    logic [6:0] segments;
    logic       dp;
    logic [3:0] digit;
    logic       tick;

    int total = 0;
    int bad = 0;

    // Reference model state (plain integers, arithmetic from the behavioural rules)
    int         m_pre;
    int         m_digit;
    logic       m_tick;
    logic       m_dp;
    logic       m_step_pending;
    logic [6:0] m_seg;
    logic [6:0] seg_tab [10];

    seg7_digit_counter #(.MAX_COUNT(8), .PRE_W(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .run      (run),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .div_sel  (div_sel),
        .segments (segments),
        .dp       (dp),
        .digit    (digit),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("digit", {3'b0, digit}, 7'(m_digit));
        chk("tick", {6'b0, tick}, {6'b0, m_tick});
        chk("segments", segments, m_seg);
        chk("dp", {6'b0, dp}, {6'b0, m_dp});
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_digit = 0;
        m_tick = 1'b0;
        m_dp = 1'b0;
        m_step_pending = 1'b0;
        m_seg = seg_tab[0];
    endtask

    // One rising edge of the reference model, using the inputs currently applied.
    task automatic model_edge();
        int p;
        bit term;
        if (!ena) begin
            m_tick = 1'b0;
            return;
        end
        p = 8 >> div_sel;
        if (p < 1) p = 1;
        term = run && (m_pre >= p - 1);
        m_seg = seg_tab[m_digit];
        if (m_step_pending) m_dp = ~m_dp;
        m_step_pending = 1'b0;
        if (run) m_pre = term ? 0 : m_pre + 1;
        if (load) begin
            m_digit = (load_val <= 9) ? int'(load_val) : 0;
            m_pre = 0;
        end else if (term) begin
            m_digit = up ? (m_digit + 1) % 10 : (m_digit + 9) % 10;
            m_step_pending = 1'b1;
        end
        m_tick = term;
    endtask

    // Called and returns at a falling edge; inputs are changed between calls.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_segments", segments, 7'h3F);
        chk("rst_digit", {3'b0, digit}, 7'd0);
        chk("rst_tick", {6'b0, tick}, 7'd0);
        chk("rst_dp", {6'b0, dp}, 7'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_tick;
        int n_dp;
        logic prev_dp;

        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
        model_reset();

        // 1. Reset, including an assertion in the middle of a running count
        @(negedge clk);
        do_reset();
        repeat (29) cycle();
        do_reset();

        // 2. Count up from reset: 10 ticks in 80 edges, 10 dp toggles by edge 81
        n_tick = 0;
        n_dp = 0;
        prev_dp = dp;
        for (int i = 0; i < 81; i++) begin
            cycle();
            if (tick) n_tick++;
            if (dp !== prev_dp) n_dp++;
            prev_dp = dp;
        end
        chk("up_tick_count", 7'(n_tick), 7'd10);
        chk("up_dp_toggles", 7'(n_dp), 7'd10);
        chk("up_wrap_digit", {3'b0, digit}, 7'd0);

        // 3. Count down from 0: first step lands on 9
        up = 1'b0;
        do_reset();
        repeat (8) cycle();
        chk("down_first_digit", {3'b0, digit}, 7'd9);
        cycle();
        chk("down_first_seg", segments, 7'h6F);
        repeat (75) cycle();

        // 4. Load colliding with the terminal edge, then an out-of-range load
        up = 1'b1;
        for (int i = 0; i < 16 && m_pre != 7; i++) cycle();
        chk("pre_aligned_7", 7'(m_pre), 7'd7);
        load = 1'b1;
        load_val = 4'd4;
        cycle();
        chk("load_coll_digit", {3'b0, digit}, 7'd4);
        chk("load_coll_tick", {6'b0, tick}, 7'd1);
        load = 1'b0;
        cycle();
        chk("load_coll_seg", segments, 7'h66);
        repeat (10) cycle();
        load = 1'b1;
        load_val = 4'd12;
        cycle();
        chk("load_12_digit", {3'b0, digit}, 7'd0);
        load = 1'b0;
        repeat (5) cycle();

        // 5. div_sel change while prescaler sits above the new terminal value
        for (int i = 0; i < 16 && m_pre != 6; i++) cycle();
        chk("pre_aligned_6", 7'(m_pre), 7'd6);
        div_sel = 3'd2;
        cycle();
        chk("divsel_immediate_tick", {6'b0, tick}, 7'd1);
        repeat (10) cycle();
        div_sel = 3'd7;
        repeat (10) cycle();
        chk("p1_tick_high", {6'b0, tick}, 7'd1);
        div_sel = 3'd0;
        repeat (3) cycle();

        // 6. Pause, then disable with other inputs wiggling, then resume
        run = 1'b0;
        repeat (20) cycle();
        run = 1'b1;
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            up = 1'($urandom);
            load = 1'($urandom);
            load_val = 4'($urandom);
            div_sel = 3'($urandom);
            cycle();
        end
        ena = 1'b1;
        load = 1'b0;
        up = 1'b1;
        div_sel = 3'd0;
        repeat (20) cycle();

        // 7. Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            ena = ($urandom_range(0, 99) < 90);
            run = ($urandom_range(0, 99) < 85);
            up = 1'($urandom);
            load = ($urandom_range(0, 99) < 5);
            load_val = 4'($urandom);
            if ($urandom_range(0, 99) < 5) div_sel = 3'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
